// File: rtl/ballot_controller.sv
// Ballot sequencer: arms one ballot per officer key edge, accepts a single candidate press,
// holds a confirmation window and then strobes the tally counters once.
module ballot_controller #(
    parameter int CONFIRM_TIME = 50_000_000,
    parameter int ARM_TIMEOUT  = 500_000_000,
    parameter int TOTAL_W      = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ballot_en,
    input  logic               close_poll,
    input  logic [2:0]         btn,
    output logic               ready_led,
    output logic [2:0]         conf_led,
    output logic [2:0]         vote_pulse,
    output logic [TOTAL_W-1:0] total_votes,
    output logic               multi_err,
    output logic               timeout,
    output logic               poll_closed
);

    localparam int TIMER_MAX = (ARM_TIMEOUT > CONFIRM_TIME) ? ARM_TIMEOUT : CONFIRM_TIME;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CONFIRM = 3'd2,
        COMMIT  = 3'd3,
        CLOSED  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [TIMER_W-1:0] timer_r, timer_s;
    logic [2:0]         sel_r, sel_s;
    logic [2:0]         btn_q_r;
    logic               ben_q_r;
    logic               close_pend_r, close_pend_s;
    logic               multi_s, timeout_s;
    logic [2:0]         press_s;
    logic               ben_rise_s, press_one_s, press_many_s;

    assign press_s      = btn & ~btn_q_r;
    assign ben_rise_s   = ballot_en & ~ben_q_r;
    assign press_one_s  = $onehot(press_s);
    assign press_many_s = (press_s != 3'b000) && !press_one_s;

    // Next-state, timer, selection and event decode
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        sel_s        = sel_r;
        close_pend_s = close_pend_r;
        multi_s      = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (close_poll || close_pend_r) begin
                    state_s = CLOSED;
                end else if (ben_rise_s) begin
                    state_s = ARMED;
                    timer_s = {TIMER_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            ARMED: begin
                close_pend_s = close_pend_r | close_poll;
                // A valid press wins over an expiry landing in the same cycle
                if (press_one_s) begin
                    sel_s   = press_s;
                    timer_s = {TIMER_W{1'b0}};
                    state_s = CONFIRM;
                end else if (timer_r == TIMER_W'(ARM_TIMEOUT - 1)) begin
                    timeout_s = 1'b1;
                    timer_s   = {TIMER_W{1'b0}};
                    state_s   = IDLE;
                end else begin
                    timer_s = timer_r + TIMER_W'(1);
                    multi_s = press_many_s;
                end
            end
            CONFIRM: begin
                close_pend_s = close_pend_r | close_poll;
                if (timer_r == TIMER_W'(CONFIRM_TIME - 1)) begin
                    timer_s = {TIMER_W{1'b0}};
                    state_s = COMMIT;
                end else begin
                    timer_s = timer_r + TIMER_W'(1);
                end
            end
            COMMIT: begin
                close_pend_s = close_pend_r | close_poll;
                sel_s        = 3'b000;
                state_s      = IDLE;
            end
            CLOSED: begin
                state_s = CLOSED;
            end
            default: begin
                state_s = IDLE;
                timer_s = {TIMER_W{1'b0}};
                sel_s   = 3'b000;
            end
        endcase
    end

    // State and registered outputs; outputs are decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            timer_r      <= {TIMER_W{1'b0}};
            sel_r        <= 3'b000;
            btn_q_r      <= 3'b000;
            ben_q_r      <= 1'b0;
            close_pend_r <= 1'b0;
            ready_led    <= 1'b0;
            conf_led     <= 3'b000;
            vote_pulse   <= 3'b000;
            total_votes  <= {TOTAL_W{1'b0}};
            multi_err    <= 1'b0;
            timeout      <= 1'b0;
            poll_closed  <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            sel_r        <= sel_s;
            btn_q_r      <= btn;
            ben_q_r      <= ballot_en;
            close_pend_r <= close_pend_s;
            ready_led    <= (state_s == ARMED);
            conf_led     <= (state_s == CONFIRM) ? sel_s : 3'b000;
            vote_pulse   <= (state_s == COMMIT) ? sel_s : 3'b000;
            multi_err    <= multi_s;
            timeout      <= timeout_s;
            poll_closed  <= (state_s == CLOSED);
            if ((state_s == COMMIT) && (total_votes != {TOTAL_W{1'b1}})) begin
                total_votes <= total_votes + TOTAL_W'(1);
            end else begin
                total_votes <= total_votes;
            end
        end
    end

endmodule

// File: doc/ballot_controller.md
Name: ballot_controller

Overview:
- Sequences voter access to the tally datapath, which holds the per-candidate vote counters and the display path.
- The presiding officer issues one ballot at a time. The block accepts exactly one valid candidate press per ballot and holds a confirmation window.
- At the end of the window it emits a single-cycle one-hot tally strobe to the counters.
- It also enforces ballot timeout, rejects simultaneous presses, keeps a saturating total-ballot count and implements poll closure.

Parameters:
- CONFIRM_TIME, 50_000_000: number of cycles spent in CONFIRM before the vote commits (1 s at 50 MHz).
- ARM_TIMEOUT, 500_000_000: maximum number of cycles a ballot stays armed without a valid press.
- TOTAL_W, 10: width of total_votes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ballot_en  in  1  officer "issue ballot" key, level, already debounced
- close_poll  in  1  officer "close poll" key, level
- btn  in  3  candidate keys, level, already debounced; bit0=BJP, bit1=CONG, bit2=NOTA
- ready_led  out  1  high while a ballot is armed
- conf_led  out  3  one-hot selected candidate, high during CONFIRM
- vote_pulse  out  3  one-hot, single-cycle tally strobe to the counters
- total_votes  out  TOTAL_W  committed ballots, saturating
- multi_err  out  1  single-cycle pulse: more than one key edge in the same cycle
- timeout  out  1  single-cycle pulse: an armed ballot expired
- poll_closed  out  1  high in CLOSED

Behaviour:
- One clock domain; all state changes on posedge clk. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE; timer = 0.
  - All outputs 0; total_votes = 0.
  - close_pend = 0; sel = 0.
  - btn_q = 0 and ben_q = 0 (previous-cycle copies of btn and ballot_en).
- Edge detection:
  - press = btn & ~btn_q; ben_rise = ballot_en & ~ben_q.
  - btn_q and ben_q update every cycle in every state.
  - A key already held when a ballot is armed does not vote; it must be released and pressed again.
- close_pend: set when close_poll = 1 in ARMED, CONFIRM or COMMIT. Cleared only by reset.
- IDLE:
  - ready_led = 0.
  - close_poll = 1 or close_pend = 1 -> CLOSED. This has priority over ben_rise.
  - Otherwise ben_rise -> ARMED, timer = 0.
- ARMED:
  - ready_led = 1. timer increments once per cycle.
  - Exactly one bit of press set -> latch sel = press, timer = 0, go to CONFIRM. This has priority over timeout in the same cycle.
  - Two or more bits of press set -> multi_err = 1 for one cycle, stay in ARMED, timer keeps running.
  - timer == ARM_TIMEOUT-1 with no valid press -> timeout = 1 for one cycle, go to IDLE. No vote is recorded.
  - ballot_en is ignored while ARMED.
- CONFIRM:
  - conf_led = sel; ready_led = 0. btn and ballot_en are ignored.
  - timer increments; at timer == CONFIRM_TIME-1 -> COMMIT.
- COMMIT (one cycle):
  - vote_pulse = sel.
  - total_votes increments unless it is already 2^TOTAL_W-1 (saturates; vote_pulse still fires).
  - sel is cleared; next state is IDLE.
- CLOSED:
  - Terminal until reset. poll_closed = 1; all other outputs 0.
  - All inputs ignored; total_votes holds.
- Latency:
  - A press edge sampled in cycle N puts the block in CONFIRM from N+1.
  - conf_led is high for cycles N+1 .. N+CONFIRM_TIME.
  - vote_pulse fires in cycle N+CONFIRM_TIME+1.
  - Exactly one vote_pulse per armed ballot, at most.
- Reset mid-CONFIRM or mid-COMMIT discards the vote: no vote_pulse, and total_votes = 0.
- vote_pulse, multi_err and timeout are registered outputs and are never high together.

Test Plan:
All scenarios use CONFIRM_TIME=4 and ARM_TIMEOUT=10.
1. Normal vote:
   - Stimulus: ben_rise, then btn=001 pressed 2 cycles later.
   - Required: conf_led=001 for 4 cycles; vote_pulse=001 for 1 cycle on the 5th cycle after the press; total_votes=1; back to IDLE.
2. Simultaneous press:
   - Stimulus: in ARMED, btn goes 000->011.
   - Required: multi_err pulses once; state stays ARMED; a later 100 press commits vote_pulse=100.
3. Held key and timeout:
   - Stimulus: btn=010 held before and through arming.
   - Required: no CONFIRM; timeout pulses after 10 cycles in ARMED; total_votes unchanged.
4. Close during vote:
   - Stimulus: close_poll pulsed during CONFIRM.
   - Required: the vote still commits; next state is CLOSED with poll_closed=1; a subsequent ben_rise and btn press have no effect.
5. Reset mid-CONFIRM:
   - Stimulus: reset asserted at the 2nd CONFIRM cycle.
   - Required: all outputs 0; no vote_pulse; total_votes=0.
6. Saturation:
   - Stimulus: with TOTAL_W=2, commit 5 votes.
   - Required: total_votes = 1,2,3,3,3; vote_pulse fires all 5 times.
